// File: rtl/ifetch_pkg.sv
// Shared defaults and types for the instruction fetch stage.
// Optional boot loader is enabled with the IFETCH_BOOT_LOAD_EN macro.
package ifetch_pkg;

  localparam int unsigned IF_ADDR_W   = 16;
  localparam int unsigned IF_DATA_W   = 32;
  localparam int unsigned IF_RESET_PC = 0;

  // Action taken by the fetch stage in the current cycle, in priority order
  typedef enum logic [1:0] {
    FETCH_ADVANCE  = 2'd0,
    FETCH_HOLD     = 2'd1,
    FETCH_REDIRECT = 2'd2,
    FETCH_BOOT     = 2'd3
  } fetch_op_e;

endpackage

// File: rtl/ifetch_hold_buf.sv
// Stall capture buffer: keeps the word shown to decode stable while decode
// stalls, then bypasses the live RAM response once released.
module ifetch_hold_buf
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W = IF_ADDR_W,
  parameter int unsigned DATA_W = IF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              release_i,
  input  logic [DATA_W-1:0] live_instr_i,
  input  logic [ADDR_W-1:0] live_pc_i,
  output logic              hold_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              hold_q, hold_d;
  logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;

  // Next-state: clear beats load, load beats release
  always_comb begin
    hold_d       = hold_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (clear_i) begin
      hold_d = 1'b0;
    end else if (load_i) begin
      hold_d       = 1'b1;
      hold_instr_d = live_instr_i;
      hold_pc_d    = live_pc_i;
    end else if (release_i) begin
      hold_d = 1'b0;
    end
  end

  // Buffer registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q       <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      hold_q       <= hold_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // Bypass mux: held word while holding, otherwise the live response
  always_comb begin
    hold_o  = hold_q;
    instr_o = hold_q ? hold_instr_q : live_instr_i;
    pc_o    = hold_q ? hold_pc_q    : live_pc_i;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of a 1-cycle synchronous-read RAM.
// Owns the PC, tracks which word the RAM is returning, buffers across
// decode stalls and handles redirects from execute.
// Optional boot loader port set is enabled with the IFETCH_BOOT_LOAD_EN macro.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = IF_ADDR_W,
  parameter int unsigned DATA_W   = IF_DATA_W,
  parameter int unsigned RESET_PC = IF_RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_data,
  output logic              imem_wren,
  input  logic [DATA_W-1:0] imem_q,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid
`ifdef IFETCH_BOOT_LOAD_EN
  ,
  input  logic              boot_mode,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
`endif
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              boot_active;
  fetch_op_e         op_c;
  logic              valid_c;
  logic              hold_flag;
  logic [DATA_W-1:0] buf_instr;
  logic [ADDR_W-1:0] buf_pc;
  logic              hold_clear, hold_load, hold_release;

`ifdef IFETCH_BOOT_LOAD_EN
  assign boot_active = boot_mode;
`else
  assign boot_active = 1'b0;
`endif

  // Classify this cycle: boot, then redirect, then stall, else advance
  always_comb begin
    op_c = FETCH_ADVANCE;
    if (boot_active) begin
      op_c = FETCH_BOOT;
    end else if (redirect_valid) begin
      op_c = FETCH_REDIRECT;
    end else if (stall) begin
      op_c = FETCH_HOLD;
    end
  end

  // Decode sees a word whenever one is buffered or arriving, unless flushed
  assign valid_c = (hold_flag | rsp_valid_q) & ~redirect_valid & ~reset & ~boot_active;

  // PC and response tracking next-state
  always_comb begin
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = rsp_valid_q;
    case (op_c)
      FETCH_BOOT: begin
        pc_d        = RESET_ADDR;
        rsp_pc_d    = '0;
        rsp_valid_d = 1'b0;
      end
      FETCH_REDIRECT: begin
        pc_d        = redirect_pc;
        rsp_valid_d = 1'b0;
      end
      FETCH_HOLD: begin
        // Re-read the frozen PC so its word is ready on release; with
        // nothing valid yet, freeze everything so no address is skipped
        if (valid_c) begin
          rsp_pc_d    = pc_q;
          rsp_valid_d = 1'b1;
        end
      end
      FETCH_ADVANCE: begin
        pc_d        = pc_q + ADDR_W'(1);
        rsp_pc_d    = pc_q;
        rsp_valid_d = 1'b1;
      end
    endcase
  end

  // PC and response registers; reset overrides every other action
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= RESET_ADDR;
      rsp_pc_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Capture only on the first stalled cycle showing a valid word
  assign hold_clear   = (op_c == FETCH_REDIRECT) || (op_c == FETCH_BOOT);
  assign hold_load    = (op_c == FETCH_HOLD) && valid_c && !hold_flag;
  assign hold_release = (op_c == FETCH_ADVANCE);

  ifetch_hold_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk_i        (clock),
    .rst_i        (reset),
    .clear_i      (hold_clear),
    .load_i       (hold_load),
    .release_i    (hold_release),
    .live_instr_i (imem_q),
    .live_pc_i    (rsp_pc_q),
    .hold_o       (hold_flag),
    .instr_o      (buf_instr),
    .pc_o         (buf_pc)
  );

  // Decode-facing outputs, zeroed when not valid
  always_comb begin
    instr_valid = valid_c;
    instr       = valid_c ? buf_instr : '0;
    instr_pc    = valid_c ? buf_pc    : '0;
  end

  // Memory port: boot loader owns it in boot mode, otherwise read-only fetch
  always_comb begin
    imem_addr = pc_q;
    imem_data = '0;
    imem_wren = 1'b0;
`ifdef IFETCH_BOOT_LOAD_EN
    if (boot_mode) begin
      imem_addr = load_addr;
      imem_data = load_data;
      imem_wren = load_we;
    end
`endif
  end

endmodule
